muldiv_unit: RTL

- Iterative 32-bit multiply/divide unit in the EX stage, alongside the ALU.
- Executes MIPS mult, multu, div and divu into architectural HI/LO registers over a fixed multi-cycle latency.
- Supports mthi/mtlo writes directly.
- The pipeline control stalls on `busy`. mfhi/mflo read `hi`/`lo` directly.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_DIV_EN (defined -> div/divu datapath present).
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = 5;

`ifdef MULDIV_DIV_EN
  localparam bit MD_DIV_EN = 1'b1;
`else
  localparam bit MD_DIV_EN = 1'b0;
`endif

  // Magnitude of a two's-complement word when the operation is signed, raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier or
// restoring divider, operating on a 64-bit {upper, lower} accumulator.
// Optional feature macro: MULDIV_DIV_EN (divide iteration only built when defined).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set,
  // then shift the whole accumulator right so the product builds up from the top.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
  end

  if (MD_DIV_EN) begin : g_div
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic [63:0] div_next;

    // Divide: shift the next dividend bit into the partial remainder and keep the
    // subtraction only when it does not borrow; the quotient bit enters at the bottom.
    always_comb begin
      rem_shift = {acc[63:32], acc[31]};
      diff      = {1'b0, rem_shift} - {2'b00, operand};
      if (diff[33]) begin
        div_next = {rem_shift[31:0], acc[30:0], 1'b0};
      end else begin
        div_next = {diff[31:0], acc[30:0], 1'b1};
      end
      acc_next = is_div ? div_next : mul_next;
    end
  end else begin : g_mul_only
    logic unused_is_div;

    // Without the divider every iteration is a multiply step.
    always_comb begin
      unused_is_div = is_div;
      acc_next      = mul_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MIPS mult/multu/div/divu unit with HI/LO registers.
// 32 iteration cycles plus one sign-fix cycle; done pulses as the new HI/LO appear.
// Optional feature macro: MULDIV_DIV_EN (defined -> div/divu supported, otherwise ignored).
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e             state;
  md_state_e             state_next;
  logic [MD_CNT_W-1:0]   count;
  logic [63:0]           acc;
  logic [63:0]           acc_step;
  logic [31:0]           operand;
  logic                  op_div;
  logic                  neg_q;
  logic                  neg_r;
  logic                  div_zero;
  logic                  accept;
  logic                  is_signed;
  logic [31:0]           fix_hi;
  logic [31:0]           fix_lo;
  logic [63:0]           prod;

  assign busy      = (state != ST_IDLE);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign accept    = (state == ST_IDLE) && start && (MD_DIV_EN || !op[1]);

  muldiv_step u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_div),
    .acc_next (acc_step)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: run for exactly MD_ITERS cycles, then one cycle of sign correction.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (count == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sign correction of the unsigned magnitude result; divide by zero forces an all-ones quotient
  // while the remainder path naturally reproduces the dividend.
  always_comb begin
    prod   = neg_q ? (64'd0 - acc) : acc;
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (MD_DIV_EN && op_div) begin
      fix_lo = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc[31:0]) : acc[31:0]);
      fix_hi = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    end
  end

  // Datapath registers: operand capture on start, one iteration per RUN cycle,
  // HI/LO written only by mthi/mtlo in IDLE or by the final FIX cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (accept) begin
            acc      <= {32'd0, abs32(a, is_signed)};
            operand  <= abs32(b, is_signed);
            op_div   <= op[1];
            neg_q    <= is_signed && (a[31] ^ b[31]);
            neg_r    <= is_signed && a[31];
            div_zero <= op[1] && (b == 32'd0);
            count    <= MD_CNT_W'(MD_ITERS - 1);
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          if (count != '0) count <= count - 1'b1;
        end
        ST_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
